// File: rtl/seq_reader_pkg.sv
// Shared types and helpers for the seq_reader sequence monitor.
package seq_reader_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        TRACK,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        MATCH,
        STALE,
        SKIP
    } sample_class_t;

    localparam int unsigned     CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Classifies a sample against the expected value, modulo 2^width.
    // Operands are zero-extended to 32 bits, so width must not exceed 32.
    function automatic sample_class_t classify_sample(
        input logic [31:0]  data,
        input logic [31:0]  expected,
        input int unsigned  width
    );
        logic [31:0] mask;
        logic [31:0] prev;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        prev = (expected - 32'd1) & mask;
        if ((data & mask) == (expected & mask)) begin
            return MATCH;
        end else if ((data & mask) == prev) begin
            return STALE;
        end else begin
            return SKIP;
        end
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module seq_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count events, stopping at the maximum value instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_reader.sv
// Sequence monitor for an incrementing producer value: locks onto the
// sequence, counts stale and skipped samples and faults after a run of
// consecutive bad samples. Optional macro SEQ_READER_SNAPSHOT_EN adds a
// capture of the first bad sample seen while tracking.
module seq_reader
    import seq_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             locked,
    output logic             in_error,
    output logic [CNT_W-1:0] stale_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [WIDTH-1:0] last_good
`ifdef SEQ_READER_SNAPSHOT_EN
    ,
    output logic             snap_valid,
    output logic [WIDTH-1:0] snap_expected,
    output logic [WIDTH-1:0] snap_data
`endif
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W = $clog2(ERR_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0] BAD_LIM  = BAD_W'(ERR_LIMIT);

    state_t           r_state,    w_state_nx;
    logic [WIDTH-1:0] r_expected, w_expected_nx;
    logic [RUN_W-1:0] r_run,      w_run_nx;
    logic [BAD_W-1:0] r_bad,      w_bad_nx;
    logic [WIDTH-1:0] r_last_good, w_last_good_nx;

    sample_class_t    w_class;
    logic [WIDTH-1:0] w_data_p1;
    logic [RUN_W-1:0] w_run_p1;
    logic [BAD_W-1:0] w_bad_p1;
    logic             w_inc_stale;
    logic             w_inc_skip;

    assign w_class   = classify_sample(32'(data), 32'(r_expected), WIDTH);
    assign w_data_p1 = data + WIDTH'(1);
    assign w_run_p1  = r_run + RUN_W'(1);
    assign w_bad_p1  = r_bad + BAD_W'(1);

    // Register FSM state and tracking datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_expected  <= '0;
            r_run       <= '0;
            r_bad       <= '0;
            r_last_good <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_expected  <= w_expected_nx;
            r_run       <= w_run_nx;
            r_bad       <= w_bad_nx;
            r_last_good <= w_last_good_nx;
        end
    end

    // Next-state and datapath update for one sample; clear overrides valid.
    always_comb begin
        w_state_nx     = r_state;
        w_expected_nx  = r_expected;
        w_run_nx       = r_run;
        w_bad_nx       = r_bad;
        w_last_good_nx = r_last_good;
        w_inc_stale    = 1'b0;
        w_inc_skip     = 1'b0;
        if (clear) begin
            w_state_nx = SEARCH;
            w_run_nx   = '0;
            w_bad_nx   = '0;
        end else if (valid) begin
            case (r_state)
                SEARCH: begin
                    w_expected_nx = w_data_p1;
                    w_run_nx      = RUN_W'(1);
                    w_state_nx    = LOCKING;
                end
                LOCKING: begin
                    w_expected_nx = w_data_p1;
                    if (w_class == MATCH) begin
                        w_run_nx       = w_run_p1;
                        w_last_good_nx = data;
                        if (w_run_p1 == RUN_LOCK) begin
                            w_state_nx = TRACK;
                            w_bad_nx   = '0;
                        end
                    end else begin
                        w_run_nx = RUN_W'(1);
                    end
                end
                TRACK: begin
                    if (w_class == MATCH) begin
                        w_expected_nx  = w_data_p1;
                        w_last_good_nx = data;
                        w_bad_nx       = '0;
                    end else begin
                        w_bad_nx = w_bad_p1;
                        if (w_class == STALE) begin
                            w_inc_stale = 1'b1;
                        end else begin
                            w_inc_skip    = 1'b1;
                            w_expected_nx = w_data_p1;
                        end
                        if (w_bad_p1 == BAD_LIM) begin
                            w_state_nx = FAULT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    seq_sat_counter #(.WIDTH(CNT_W)) u_stale_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_inc_stale),
        .count (stale_cnt)
    );

    seq_sat_counter #(.WIDTH(CNT_W)) u_skip_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_inc_skip),
        .count (skip_cnt)
    );

    assign locked    = (r_state == TRACK);
    assign in_error  = (r_state == FAULT);
    assign last_good = r_last_good;

`ifdef SEQ_READER_SNAPSHOT_EN
    logic             r_snap_valid;
    logic [WIDTH-1:0] r_snap_expected;
    logic [WIDTH-1:0] r_snap_data;

    // Hold the first bad tracking sample and its expected value until clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_valid    <= 1'b0;
            r_snap_expected <= '0;
            r_snap_data     <= '0;
        end else if (clear) begin
            r_snap_valid    <= 1'b0;
            r_snap_expected <= '0;
            r_snap_data     <= '0;
        end else if (valid && (r_state == TRACK) && (w_class != MATCH) && !r_snap_valid) begin
            r_snap_valid    <= 1'b1;
            r_snap_expected <= r_expected;
            r_snap_data     <= data;
        end
    end

    assign snap_valid    = r_snap_valid;
    assign snap_expected = r_snap_expected;
    assign snap_data     = r_snap_data;
`endif

endmodule
